// File: rtl/cv32e40p_rf_pkg.sv
// Sizing and address-mapping helpers for the scoreboarded register file.
// With ADDR_WIDTH=5 all five bits select an X register; wider addresses spend the MSB on the bank.
package cv32e40p_rf_pkg;

  function automatic int x_words(input int addr_width);
    return (addr_width > 5) ? (1 << (addr_width - 1)) : (1 << addr_width);
  endfunction

  function automatic bit has_f_bank(input int addr_width, input bit fpu, input bit zfinx);
    return fpu && !zfinx && (addr_width > 5);
  endfunction

  function automatic int f_words(input int addr_width, input bit fpu, input bit zfinx);
    return has_f_bank(addr_width, fpu, zfinx) ? x_words(addr_width) : 0;
  endfunction

  function automatic int cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  localparam int PENDING_CNT_W = cnt_width(4);

  // F registers sit above the X words; without an F bank the MSB simply aliases onto X
  function automatic int word_index(input int addr, input int addr_width, input bit f_bank);
    int xw;
    int low;
    xw  = x_words(addr_width);
    low = addr % xw;
    if (f_bank && (((addr >> (addr_width - 1)) & 1) == 1)) return xw + low;
    return low;
  endfunction

endpackage

// File: rtl/cv32e40p_register_file_sb_if.sv
// Reservation handshake between the issue logic (master) and the register file (slave).
interface cv32e40p_register_file_sb_if
  import cv32e40p_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_W      = PENDING_CNT_W
);
  logic                  rsv_valid_i;
  logic [ADDR_WIDTH-1:0] rsv_addr_i;
  logic                  rsv_ready_o;
  logic                  flush_i;
  logic [CNT_W-1:0]      pending_cnt_o;

  modport master (output rsv_valid_i, rsv_addr_i, flush_i, input rsv_ready_o, pending_cnt_o);
  modport slave  (input rsv_valid_i, rsv_addr_i, flush_i, output rsv_ready_o, pending_cnt_o);
endinterface

// File: rtl/cv32e40p_rf_scoreboard.sv
// Per-register busy bits for outstanding long-latency writes, with reserve/retire/flush.
module cv32e40p_rf_scoreboard #(
  parameter int NUM_WORDS   = 32,
  parameter int IDX_W       = 5,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rsv_valid,
  input  logic [IDX_W-1:0]     rsv_idx,
  input  logic                 ret_valid,
  input  logic [IDX_W-1:0]     ret_idx,
  input  logic                 flush,
  output logic [NUM_WORDS-1:0] busy,
  output logic                 rsv_ready,
  output logic [CNT_W-1:0]     pending_cnt
);

  logic retire;
  logic grant;

  assign retire = ret_valid && busy[ret_idx];

  // x0 is acknowledged without consuming a slot; a retiring slot may be reused in the same cycle
  assign rsv_ready = (rsv_idx == '0) ? !flush
                   : (!busy[rsv_idx] && ((pending_cnt < CNT_W'(MAX_PENDING)) || retire) && !flush);

  assign grant = rsv_valid && rsv_ready && (rsv_idx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else if (flush) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (retire) busy[ret_idx] <= 1'b0;
      if (grant)  busy[rsv_idx] <= 1'b1;
      pending_cnt <= pending_cnt + CNT_W'(grant) - CNT_W'(retire);
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    pending_cnt <= CNT_W'(MAX_PENDING));

endmodule

// File: rtl/cv32e40p_register_file_sb.sv
// Flip-flop register file with optional F bank, write-to-read bypass and a write scoreboard.
module cv32e40p_register_file_sb
  import cv32e40p_rf_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_READ    = 3,
  parameter int FPU         = 0,
  parameter int PULP_ZFINX  = 0,
  parameter int BYPASS      = 1,
  parameter int MAX_PENDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 scan_cg_en_i,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_READ-1:0]                  rbusy_o,
  input  logic [ADDR_WIDTH-1:0]                waddr_a_i,
  input  logic [DATA_WIDTH-1:0]                wdata_a_i,
  input  logic                                 we_a_i,
  input  logic [ADDR_WIDTH-1:0]                waddr_b_i,
  input  logic [DATA_WIDTH-1:0]                wdata_b_i,
  input  logic                                 we_b_i,
  cv32e40p_register_file_sb_if.slave           rsv
);

  localparam bit F_BANK      = has_f_bank(ADDR_WIDTH, FPU != 0, PULP_ZFINX != 0);
  localparam int TOTAL_WORDS = x_words(ADDR_WIDTH) + f_words(ADDR_WIDTH, FPU != 0, PULP_ZFINX != 0);
  localparam int IDX_W       = $clog2(TOTAL_WORDS);
  localparam int CNT_W       = cnt_width(MAX_PENDING);

  logic [DATA_WIDTH-1:0]         mem [TOTAL_WORDS];
  logic [IDX_W-1:0]              widx_a;
  logic [IDX_W-1:0]              widx_b;
  logic [IDX_W-1:0]              rsv_idx;
  logic [NUM_READ-1:0][IDX_W-1:0] ridx;
  logic [TOTAL_WORDS-1:0]        busy;
  logic                          unused_scan;

  assign unused_scan = scan_cg_en_i;

  assign widx_a  = IDX_W'(word_index(int'(waddr_a_i), ADDR_WIDTH, F_BANK));
  assign widx_b  = IDX_W'(word_index(int'(waddr_b_i), ADDR_WIDTH, F_BANK));
  assign rsv_idx = IDX_W'(word_index(int'(rsv.rsv_addr_i), ADDR_WIDTH, F_BANK));

  // Word 0 is x0 and is never written; port B has priority over port A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOTAL_WORDS; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < TOTAL_WORDS; i++) begin
        if (we_b_i && (widx_b == IDX_W'(i)))      mem[i] <= wdata_b_i;
        else if (we_a_i && (widx_a == IDX_W'(i))) mem[i] <= wdata_a_i;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      ridx[k]    = IDX_W'(word_index(int'(raddr_i[k]), ADDR_WIDTH, F_BANK));
      rdata_o[k] = mem[ridx[k]];
      if (ridx[k] == '0)
        rdata_o[k] = '0;
      else if ((BYPASS != 0) && we_b_i && (ridx[k] == widx_b))
        rdata_o[k] = wdata_b_i;
      else if ((BYPASS != 0) && we_a_i && (ridx[k] == widx_a))
        rdata_o[k] = wdata_a_i;
      rbusy_o[k] = busy[ridx[k]] && !(we_b_i && (ridx[k] == widx_b));
    end
  end

  cv32e40p_rf_scoreboard #(
    .NUM_WORDS   (TOTAL_WORDS),
    .IDX_W       (IDX_W),
    .MAX_PENDING (MAX_PENDING),
    .CNT_W       (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsv_valid   (rsv.rsv_valid_i),
    .rsv_idx     (rsv_idx),
    .ret_valid   (we_b_i && (widx_b != '0)),
    .ret_idx     (widx_b),
    .flush       (rsv.flush_i),
    .busy        (busy),
    .rsv_ready   (rsv.rsv_ready_o),
    .pending_cnt (rsv.pending_cnt_o)
  );

  // Port A landing on a reserved register is a WAW hazard created by the issuer
  a_no_waw_on_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(we_a_i && (widx_a != '0) && busy[widx_a]));

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// Bench for the scoreboarded register file: directed cases plus randomized traffic against a model.
module tb_cv32e40p_register_file_sb;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   cmpEn    = 1'b0;

  always #5 clk = ~clk;

  // shared stimulus for d0 (bypass) and d1 (no bypass)
  logic [2:0][4:0]  raddr;
  logic [4:0]       waddr_a, waddr_b, rsv_addr;
  logic [31:0]      wdata_a, wdata_b;
  logic             we_a, we_b, rsv_valid, flush;
  logic [2:0][31:0] rdata0, rdata1;
  logic [2:0]       rbusy0, rbusy1;

  // d2: MAX_PENDING=2
  logic [2:0][4:0]  raddr2;
  logic [4:0]       waddr_b2, rsv_addr2;
  logic [31:0]      wdata_b2;
  logic             we_b2, rsv_valid2;
  logic [2:0][31:0] rdata2;
  logic [2:0]       rbusy2;

  // d3: FPU bank, d4: FPU with ZFINX aliasing
  logic [2:0][5:0]  raddr3;
  logic [5:0]       waddr_a3, waddr_b3;
  logic [31:0]      wdata_a3, wdata_b3;
  logic             we_a3, we_b3;
  logic [2:0][31:0] rdata3, rdata4;
  logic [2:0]       unusedBusy3, unusedBusy4;

  cv32e40p_register_file_sb_if #(.ADDR_WIDTH(5), .CNT_W(3)) if0 ();
  cv32e40p_register_file_sb_if #(.ADDR_WIDTH(5), .CNT_W(3)) if1 ();
  cv32e40p_register_file_sb_if #(.ADDR_WIDTH(5), .CNT_W(2)) if2 ();
  cv32e40p_register_file_sb_if #(.ADDR_WIDTH(6), .CNT_W(3)) if3 ();
  cv32e40p_register_file_sb_if #(.ADDR_WIDTH(6), .CNT_W(3)) if4 ();

  assign if0.rsv_valid_i = rsv_valid;
  assign if0.rsv_addr_i  = rsv_addr;
  assign if0.flush_i     = flush;
  assign if1.rsv_valid_i = rsv_valid;
  assign if1.rsv_addr_i  = rsv_addr;
  assign if1.flush_i     = flush;
  assign if2.rsv_valid_i = rsv_valid2;
  assign if2.rsv_addr_i  = rsv_addr2;
  assign if2.flush_i     = 1'b0;
  assign if3.rsv_valid_i = 1'b0;
  assign if3.rsv_addr_i  = 6'd0;
  assign if3.flush_i     = 1'b0;
  assign if4.rsv_valid_i = 1'b0;
  assign if4.rsv_addr_i  = 6'd0;
  assign if4.flush_i     = 1'b0;

  cv32e40p_register_file_sb #(.BYPASS(1)) d0 (
    .clk(clk), .rst_n(rst_n), .scan_cg_en_i(1'b0), .raddr_i(raddr), .rdata_o(rdata0), .rbusy_o(rbusy0),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv(if0.slave));

  cv32e40p_register_file_sb #(.BYPASS(0)) d1 (
    .clk(clk), .rst_n(rst_n), .scan_cg_en_i(1'b0), .raddr_i(raddr), .rdata_o(rdata1), .rbusy_o(rbusy1),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv(if1.slave));

  cv32e40p_register_file_sb #(.MAX_PENDING(2)) d2 (
    .clk(clk), .rst_n(rst_n), .scan_cg_en_i(1'b0), .raddr_i(raddr2), .rdata_o(rdata2), .rbusy_o(rbusy2),
    .waddr_a_i(5'd0), .wdata_a_i(32'd0), .we_a_i(1'b0),
    .waddr_b_i(waddr_b2), .wdata_b_i(wdata_b2), .we_b_i(we_b2), .rsv(if2.slave));

  cv32e40p_register_file_sb #(.ADDR_WIDTH(6), .FPU(1), .PULP_ZFINX(0)) d3 (
    .clk(clk), .rst_n(rst_n), .scan_cg_en_i(1'b0), .raddr_i(raddr3), .rdata_o(rdata3), .rbusy_o(unusedBusy3),
    .waddr_a_i(waddr_a3), .wdata_a_i(wdata_a3), .we_a_i(we_a3),
    .waddr_b_i(waddr_b3), .wdata_b_i(wdata_b3), .we_b_i(we_b3), .rsv(if3.slave));

  cv32e40p_register_file_sb #(.ADDR_WIDTH(6), .FPU(1), .PULP_ZFINX(1)) d4 (
    .clk(clk), .rst_n(rst_n), .scan_cg_en_i(1'b0), .raddr_i(raddr3), .rdata_o(rdata4), .rbusy_o(unusedBusy4),
    .waddr_a_i(waddr_a3), .wdata_a_i(wdata_a3), .we_a_i(we_a3),
    .waddr_b_i(waddr_b3), .wdata_b_i(wdata_b3), .we_b_i(we_b3), .rsv(if4.slave));

  // Architectural model of d0/d1: register values and the set of reserved registers
  logic [31:0] mRegs [32];
  bit          mBusy [32];

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = 32'd0;
      mBusy[i] = 1'b0;
    end
  endtask

  function automatic int popCount();
    int n = 0;
    for (int i = 0; i < 32; i++) if (mBusy[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we_b && waddr_b == a) return wdata_b;
    if (byp && we_a && waddr_a == a) return wdata_a;
    return mRegs[a];
  endfunction

  function automatic bit expBusy(input logic [4:0] a);
    return mBusy[a] && !(we_b && waddr_b == a);
  endfunction

  function automatic bit expReady();
    bit retiring;
    retiring = we_b && (waddr_b != 5'd0) && mBusy[waddr_b];
    if (rsv_addr == 5'd0) return !flush;
    return !mBusy[rsv_addr] && (popCount() < 4 || retiring) && !flush;
  endfunction

  task automatic modelUpdate();
    bit retiring, granted;
    retiring = we_b && (waddr_b != 5'd0) && mBusy[waddr_b];
    granted  = rsv_valid && expReady() && (rsv_addr != 5'd0);
    if (we_a && waddr_a != 5'd0) mRegs[waddr_a] = wdata_a;
    if (we_b && waddr_b != 5'd0) mRegs[waddr_b] = wdata_b;
    if (flush) begin
      for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
    end else begin
      if (retiring) mBusy[waddr_b] = 1'b0;
      if (granted)  mBusy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idleAll();
    raddr = '0; waddr_a = '0; waddr_b = '0; rsv_addr = '0;
    wdata_a = '0; wdata_b = '0; we_a = 1'b0; we_b = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
  endtask

  // Every negedge the d0/d1 outputs must match the model for the current inputs
  always @(negedge clk) begin
    if (cmpEn && rst_n) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("cyc rdata0[%0d]", k), rdata0[k], expRead(raddr[k], 1'b1));
        checkOutput($sformatf("cyc rdata1[%0d]", k), rdata1[k], expRead(raddr[k], 1'b0));
        checkOutput($sformatf("cyc rbusy0[%0d]", k), 32'(rbusy0[k]), 32'(expBusy(raddr[k])));
        checkOutput($sformatf("cyc rbusy1[%0d]", k), 32'(rbusy1[k]), 32'(expBusy(raddr[k])));
      end
      checkOutput("cyc rsv_ready0", 32'(if0.rsv_ready_o), 32'(expReady()));
      checkOutput("cyc rsv_ready1", 32'(if1.rsv_ready_o), 32'(expReady()));
      checkOutput("cyc pending0", 32'(if0.pending_cnt_o), 32'(popCount()));
      checkOutput("cyc pending1", 32'(if1.pending_cnt_o), 32'(popCount()));
    end
  end

  task automatic applyStimulus();
    int  start;
    bit  found;
    for (int k = 0; k < 3; k++) raddr[k] = 5'($urandom_range(0, 15));
    we_a    = 1'($urandom_range(0, 1));
    waddr_a = 5'($urandom_range(0, 15));
    wdata_a = $urandom;
    if (we_a && mBusy[waddr_a]) we_a = 1'b0;
    we_b    = ($urandom_range(0, 2) != 0);
    waddr_b = 5'($urandom_range(0, 15));
    wdata_b = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      start = $urandom_range(0, 15);
      found = 1'b0;
      for (int j = 0; j < 16; j++) begin
        if (!found && mBusy[(start + j) % 16]) begin
          waddr_b = 5'((start + j) % 16);
          found   = 1'b1;
        end
      end
    end
    if ($urandom_range(0, 3) == 0) raddr[0] = waddr_a;
    if ($urandom_range(0, 3) == 0) raddr[1] = waddr_b;
    rsv_valid = 1'($urandom_range(0, 1));
    rsv_addr  = 5'($urandom_range(0, 15));
    flush     = ($urandom_range(0, 31) == 0);
    @(negedge clk);
    stepCycle();
  endtask

  initial begin
    idleAll();
    raddr2 = '0; waddr_b2 = '0; rsv_addr2 = '0; wdata_b2 = '0; we_b2 = 1'b0; rsv_valid2 = 1'b0;
    raddr3 = '0; waddr_a3 = '0; waddr_b3 = '0; wdata_a3 = '0; wdata_b3 = '0; we_a3 = 1'b0; we_b3 = 1'b0;
    clearModel();
    rst_n = 1'b0;
    raddr = {5'd5, 5'd5, 5'd5};
    rsv_addr = 5'd10;
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset rdata0", rdata0[k], 32'd0);
      checkOutput("reset rbusy0", 32'(rbusy0[k]), 32'd0);
    end
    checkOutput("reset rsv_ready", 32'(if0.rsv_ready_o), 32'd1);
    checkOutput("reset pending", 32'(if0.pending_cnt_o), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    cmpEn = 1'b1;

    // write x5 via A: bypassed on d0, not yet stored on d1
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr = {5'd5, 5'd5, 5'd5};
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("x5 bypass d0", rdata0[k], 32'hDEADBEEF);
      checkOutput("x5 nobypass d1", rdata1[k], 32'd0);
    end
    stepCycle();
    we_a = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("x5 stored d0", rdata0[k], 32'hDEADBEEF);
      checkOutput("x5 stored d1", rdata1[k], 32'hDEADBEEF);
    end
    stepCycle();

    // A and B on x7: B wins; then x0 write ignored
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h1;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h2;
    raddr = {5'd5, 5'd0, 5'd7};
    @(negedge clk);
    checkOutput("x7 bypass B wins", rdata0[0], 32'h2);
    stepCycle();
    we_b = 1'b0; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("x7 stored", rdata1[0], 32'h2);
    checkOutput("x0 not bypassed", rdata0[1], 32'd0);
    stepCycle();
    we_a = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    @(negedge clk);
    checkOutput("x0 stored", rdata1[1], 32'd0);
    checkOutput("rsv x10 ready", 32'(if0.rsv_ready_o), 32'd1);
    stepCycle();

    // reservation and retire of x10
    rsv_valid = 1'b0; raddr = {5'd0, 5'd0, 5'd10};
    @(negedge clk);
    checkOutput("x10 busy", 32'(rbusy0[0]), 32'd1);
    checkOutput("pending 1", 32'(if0.pending_cnt_o), 32'd1);
    stepCycle();
    we_b = 1'b1; waddr_b = 5'd10; wdata_b = 32'h55;
    @(negedge clk);
    checkOutput("x10 retire rbusy", 32'(rbusy0[0]), 32'd0);
    checkOutput("x10 retire bypass", rdata0[0], 32'h55);
    checkOutput("pending still 1", 32'(if0.pending_cnt_o), 32'd1);
    stepCycle();
    we_b = 1'b0;
    @(negedge clk);
    checkOutput("pending 0 after retire", 32'(if0.pending_cnt_o), 32'd0);
    stepCycle();

    // double reservation blocked, then flush with three pending
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    stepCycle();
    @(negedge clk);
    checkOutput("rsv busy x4 blocked", 32'(if0.rsv_ready_o), 32'd0);
    stepCycle();
    rsv_addr = 5'd8;
    stepCycle();
    rsv_addr = 5'd9;
    stepCycle();
    rsv_valid = 1'b0; flush = 1'b1; raddr = {5'd9, 5'd8, 5'd4};
    @(negedge clk);
    checkOutput("pending 3", 32'(if0.pending_cnt_o), 32'd3);
    checkOutput("busy 4/8/9", 32'(rbusy0), 32'h7);
    stepCycle();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush pending 0", 32'(if0.pending_cnt_o), 32'd0);
    checkOutput("flush busy 0", 32'(rbusy0), 32'h0);
    stepCycle();
    idleAll();

    // d2 capacity test in parallel with d3/d4 bank tests
    rsv_valid2 = 1'b1; rsv_addr2 = 5'd1;
    we_a3 = 1'b1; waddr_a3 = 6'd32; wdata_a3 = 32'hA5;
    we_b3 = 1'b1; waddr_b3 = 6'd37; wdata_b3 = 32'h77;
    stepCycle();
    rsv_addr2 = 5'd2;
    we_a3 = 1'b0; we_b3 = 1'b0; raddr3 = {6'd5, 6'd0, 6'd32};
    @(negedge clk);
    checkOutput("f0 reads A5", rdata3[0], 32'hA5);
    checkOutput("x0 with F bank", rdata3[1], 32'd0);
    checkOutput("x5 untouched by f5", rdata3[2], 32'd0);
    checkOutput("zfinx 32 is x0", rdata4[0], 32'd0);
    checkOutput("zfinx x5 aliased", rdata4[2], 32'h77);
    stepCycle();
    rsv_addr2 = 5'd3;
    raddr3 = {6'd5, 6'd37, 6'd37};
    @(negedge clk);
    checkOutput("full rsv blocked", 32'(if2.rsv_ready_o), 32'd0);
    checkOutput("f5 reads 77", rdata3[0], 32'h77);
    checkOutput("zfinx 37 reads x5", rdata4[1], 32'h77);
    checkOutput("zfinx x5 reads 77", rdata4[2], 32'h77);
    checkOutput("fpu rsv_ready idle", 32'(if3.rsv_ready_o), 32'd1);
    checkOutput("fpu pending idle", 32'(if3.pending_cnt_o) + 32'(if4.pending_cnt_o), 32'd0);
    stepCycle();
    we_b2 = 1'b1; waddr_b2 = 5'd1; wdata_b2 = 32'h11;
    @(negedge clk);
    checkOutput("full rsv with retire", 32'(if2.rsv_ready_o), 32'd1);
    checkOutput("pending2 at 2", 32'(if2.pending_cnt_o), 32'd2);
    stepCycle();
    rsv_valid2 = 1'b0; we_b2 = 1'b0; raddr2 = {5'd2, 5'd1, 5'd3};
    @(negedge clk);
    checkOutput("pending2 stays 2", 32'(if2.pending_cnt_o), 32'd2);
    checkOutput("busy2 {2,1,3}", 32'(rbusy2), 32'h5);
    checkOutput("x1 retired data", rdata2[1], 32'h11);
    stepCycle();

    for (int n = 0; n < 3000; n++) applyStimulus();

    // asynchronous reset while data and a reservation are live
    idleAll(); flush = 1'b1;
    @(negedge clk); stepCycle();
    flush = 1'b0; we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'h12345678;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    @(negedge clk); stepCycle();
    we_a = 1'b0; rsv_valid = 1'b0; raddr = {5'd12, 5'd3, 5'd12};
    @(negedge clk);
    checkOutput("pre-reset x12", rdata0[0], 32'h12345678);
    checkOutput("pre-reset x3 busy", 32'(rbusy0[1]), 32'd1);
    checkOutput("pre-reset rsv_ready", 32'(if0.rsv_ready_o), 32'd0);
    #2 rst_n = 1'b0; cmpEn = 1'b0;
    #1;
    checkOutput("async reset x12", rdata0[0], 32'd0);
    checkOutput("async reset busy", 32'(rbusy0[1]), 32'd0);
    checkOutput("async reset pending", 32'(if0.pending_cnt_o), 32'd0);
    checkOutput("async reset rsv_ready", 32'(if0.rsv_ready_o), 32'd1);
    clearModel();
    @(posedge clk); #1;
    rst_n = 1'b1; cmpEn = 1'b1;

    for (int n = 0; n < 300; n++) applyStimulus();

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
